// File: rtl/idex_hazard_unit_if.sv
// Interface bundling the ID/EX hazard controller's pipeline-facing signals.
// The pipeline side uses the master modport and the hazard unit uses the slave modport.
// The optional performance counters appear only when HAZARD_PERF_EN is defined.
interface idex_hazard_unit_if #(
  parameter int REG_W = 6
);
  logic             idex_memrd;
  logic             idex_regwrt;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             redirect;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       hz_state;
`ifdef HAZARD_PERF_EN
  logic [15:0]      stall_events;
  logic [15:0]      flush_events;
`endif

  modport master (
    output idex_memrd, idex_regwrt, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt, redirect,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, hz_state
`ifdef HAZARD_PERF_EN
    , input stall_events, flush_events
`endif
  );

  modport slave (
    input  idex_memrd, idex_regwrt, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt, redirect,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, hz_state
`ifdef HAZARD_PERF_EN
    , output stall_events, flush_events
`endif
  );
endinterface

// File: rtl/idex_hazard_unit.sv
// ID/EX hazard controller.
// - Load-use hazards stall the PC and IF/ID and insert bubbles into ID/EX.
// - Taken redirects flush IF/ID and bubble ID/EX for a fixed window.
// - A redirect always wins over a load-use hazard, in every state.
// - Outputs are combinational from the state and the inputs.
// - All outputs are forced low while rst_n is asserted.
// Optional feature macro HAZARD_PERF_EN adds saturating stall and flush event counters.
module idex_hazard_unit #(
  parameter int REG_W        = 6,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  idex_hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit         STALL_MULTI  = (LOAD_STALL > 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu_s;
  logic       pc_hold_s, ifid_hold_s, idex_bubble_s, ifid_flush_s;

  // Load-use detection; register 0 is hardwired and never creates a hazard.
  assign lu_s = hz.idex_memrd & hz.idex_regwrt & (hz.idex_rd != {REG_W{1'b0}}) &
                ((hz.idex_rd == hz.ifid_rs) | (hz.ifid_uses_rt & (hz.idex_rd == hz.ifid_rt)));

  // State and window counter, cleared asynchronously so reset can land mid-stall or mid-flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control outputs; a redirect preempts whatever the FSM was doing.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;
    if (hz.redirect) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      if (FLUSH_MULTI) begin
        cnt_d   = FLUSH_RELOAD;
        state_d = ST_FLUSH;
      end else begin
        cnt_d   = 4'd0;
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu_s) begin
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_bubble_s = 1'b1;
            if (STALL_MULTI) begin
              cnt_d   = STALL_RELOAD;
              state_d = ST_STALL;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          pc_hold_s     = 1'b1;
          ifid_hold_s   = 1'b1;
          idex_bubble_s = 1'b1;
          cnt_d         = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_STALL;
          end
        end
        ST_FLUSH: begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          cnt_d         = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FLUSH;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign hz.pc_hold     = rst_n & pc_hold_s;
  assign hz.ifid_hold   = rst_n & ifid_hold_s;
  assign hz.idex_bubble = rst_n & idex_bubble_s;
  assign hz.ifid_flush  = rst_n & ifid_flush_s;
  assign hz.hz_state    = rst_n ? state_q : ST_RUN;

`ifdef HAZARD_PERF_EN
  logic        stall_start_s;
  logic [15:0] stall_events_q;
  logic [15:0] flush_events_q;

  assign stall_start_s = (state_q == ST_RUN) & ~hz.redirect & lu_s;

  // Saturating event counters for stalls started from RUN and for accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_events_q <= 16'd0;
      flush_events_q <= 16'd0;
    end else begin
      if (stall_start_s && (stall_events_q != 16'hFFFF)) begin
        stall_events_q <= stall_events_q + 16'd1;
      end
      if (hz.redirect && (flush_events_q != 16'hFFFF)) begin
        flush_events_q <= flush_events_q + 16'd1;
      end
    end
  end

  assign hz.stall_events = stall_events_q;
  assign hz.flush_events = flush_events_q;
`endif

endmodule
